itlb_walker: RTL

//  Miss handler that refills itlb. Catches a user-mode itlb miss and fetches the PTE

---
 rtl/itlb_walker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/itlb_walker.sv
// Refill engine for the itlb: on a user-mode miss, reads the PTE from a one-level page table,
// then either pulses the itlb write port or raises a held page fault.
module itlb_walker #(
  parameter logic [19:0] PT_BASE  = 20'h10000,
  parameter int          PT_IDX_W = 10,
  parameter int          TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        miss,
  input  logic [19:0] miss_vpn,
  output logic        busy,
  output logic        write_en,
  output logic [19:0] write_vpn,
  output logic [7:0]  write_ppn,
  output logic        fault,
  output logic [19:0] fault_vpn,
  input  logic        fault_ack,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FILL, SETTLE, FAULT} state_t;

  state_t        state, state_d;
  logic [19:0]   vpn_q, vpn_d;
  logic [TW-1:0] timer, timer_d;

  logic        busy_d, write_en_d, fault_d, mem_req_d;
  logic [19:0] write_vpn_d, fault_vpn_d, mem_addr_d;
  logic [7:0]  write_ppn_d;

  logic unused_pte_bits;
  assign unused_pte_bits = ^mem_rdata[30:28];

  function automatic logic pte_hit(input logic [31:0] pte, input logic [19:0] vpn);
    return pte[31] && (pte[27:8] == vpn);
  endfunction

  // Byte offset into the table is the low VPN bits scaled by the 4-byte PTE; the add wraps.
  function automatic logic [19:0] pte_addr(input logic [19:0] vpn);
    logic [19:0] off;
    off = '0;
    off[PT_IDX_W+1:0] = {vpn[PT_IDX_W-1:0], 2'b00};
    return PT_BASE + off;
  endfunction

  always_comb begin
    state_d     = state;
    vpn_d       = vpn_q;
    timer_d     = timer;
    write_vpn_d = write_vpn;
    write_ppn_d = write_ppn;
    fault_vpn_d = fault_vpn;
    mem_addr_d  = mem_addr;
    case (state)
      IDLE: begin
        if (miss && !mode) begin
          vpn_d      = miss_vpn;
          mem_addr_d = pte_addr(miss_vpn);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer + 1'b1;
        if (mem_rvalid) begin
          if (pte_hit(mem_rdata, vpn_q)) begin
            write_vpn_d = vpn_q;
            write_ppn_d = mem_rdata[7:0];
            state_d     = FILL;
          end else begin
            fault_vpn_d = vpn_q;
            state_d     = FAULT;
          end
        end else if (timer == TLAST) begin
          fault_vpn_d = vpn_q;
          state_d     = FAULT;
        end
      end
      FILL:   state_d = SETTLE;
      // The itlb entry lands on the FILL edge, so a miss seen here is stale.
      SETTLE: state_d = IDLE;
      FAULT: begin
        if (fault_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d != IDLE);
    mem_req_d  = (state_d == REQ);
    write_en_d = (state_d == FILL);
    fault_d    = (state_d == FAULT);
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      write_en  <= 1'b0;
      write_vpn <= '0;
      write_ppn <= '0;
      fault     <= 1'b0;
      fault_vpn <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state     <= state_d;
      busy      <= busy_d;
      write_en  <= write_en_d;
      write_vpn <= write_vpn_d;
      write_ppn <= write_ppn_d;
      fault     <= fault_d;
      fault_vpn <= fault_vpn_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
    end
  end

  // Walk context: always reloaded before use
  always_ff @(posedge clk) begin
    vpn_q <= vpn_d;
    timer <= timer_d;
  end

endmodule
